carregador_ram: RTL and testbench

Sequential loader sitting directly upstream of the SAP-1 16×8 program RAM. While programming mode is active, it accepts program bytes from a byte source over a valid/ready handshake, such as a switch debouncer or a serial receiver. It writes each byte to consecutive RAM addresses 0..15 with a setup/strobe/hold write sequence, because the RAM write is level-sensitive. It reports progress, completion and overflow to the front panel.

---
 rtl/carregador_ram_if.sv | 28 ++
 rtl/carregador_ram.sv | 177 +++++++++++++++++
 tb/tb_carregador_ram.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/carregador_ram_if.sv
// Byte-source handshake, RAM write bus and front-panel status of the SAP-1 program loader.
// The loader connects through the slave modport; the driving environment uses master.
interface carregador_ram_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_ce;
  logic       ram_leitura_escrita;
  logic       ram_run_prog;
  logic       prog_busy;
  logic       prog_done;
  logic [4:0] byte_count;
  logic       erro_overflow;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, ram_addr, ram_data, ram_ce, ram_leitura_escrita, ram_run_prog,
    output prog_busy, prog_done, byte_count, erro_overflow
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, ram_addr, ram_data, ram_ce, ram_leitura_escrita, ram_run_prog,
    input  prog_busy, prog_done, byte_count, erro_overflow
  );
endinterface

// File: rtl/carregador_ram.sv
// Sequential loader for the SAP-1 16x8 program RAM: accepts bytes over valid/ready and
// writes them to addresses 0..15 with a setup/strobe/hold sequence (RAM write is level-sensitive).
module carregador_ram #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic            i_clk,
  input  logic            i_clr_n,
  input  logic            i_prog_mode,
  carregador_ram_if.slave bus
);

  typedef enum logic [2:0] {
    OCIOSO, ESPERA, SETUP, STROBE, HOLD, CHEIO
  } estado_t;

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);

  estado_t    r_estado;
  logic [7:0] r_cnt;
  logic       r_abort;
  logic       r_byte_ready;
  logic [3:0] r_addr;
  logic [7:0] r_data;
  logic       r_ce;
  logic       r_le;
  logic       r_run;
  logic       r_busy;
  logic       r_done;
  logic [4:0] r_count;
  logic       r_erro;

  logic [4:0] w_count_inc;
  assign w_count_inc = r_count + 5'd1;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_estado     <= OCIOSO;
      r_cnt        <= 8'd0;
      r_abort      <= 1'b0;
      r_byte_ready <= 1'b0;
      r_addr       <= 4'd0;
      r_data       <= 8'd0;
      r_ce         <= 1'b0;
      r_le         <= 1'b1;
      r_run        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_count      <= 5'd0;
      r_erro       <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (i_prog_mode) begin
            r_estado     <= ESPERA;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_count      <= 5'd0;
            r_erro       <= 1'b0;
          end
        end

        ESPERA: begin
          // Acceptance wins over a simultaneous prog_mode drop; SETUP then aborts it.
          if (bus.byte_valid) begin
            r_estado     <= SETUP;
            r_byte_ready <= 1'b0;
            r_data       <= bus.byte_data;
            r_addr       <= r_count[3:0];
            r_cnt        <= 8'd0;
            r_abort      <= 1'b0;
          end else if (!i_prog_mode) begin
            r_estado     <= OCIOSO;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_addr       <= 4'd0;
            r_data       <= 8'd0;
          end
        end

        SETUP: begin
          if (!i_prog_mode) begin
            r_estado <= OCIOSO;
            r_busy   <= 1'b0;
            r_addr   <= 4'd0;
            r_data   <= 8'd0;
          end else if (r_cnt == SETUP_LAST) begin
            r_estado <= STROBE;
            r_cnt    <= 8'd0;
            r_ce     <= 1'b1;
            r_le     <= 1'b0;
            r_run    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        STROBE: begin
          // A dropped prog_mode cuts the strobe but still lets HOLD run its full length.
          if (!i_prog_mode || r_cnt == STROBE_LAST) begin
            r_estado <= HOLD;
            r_cnt    <= 8'd0;
            r_abort  <= !i_prog_mode;
            r_ce     <= 1'b0;
            r_le     <= 1'b1;
            r_run    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        HOLD: begin
          if (r_cnt != HOLD_LAST) begin
            r_cnt <= r_cnt + 8'd1;
          end else if (r_abort) begin
            r_estado <= OCIOSO;
            r_busy   <= 1'b0;
            r_addr   <= 4'd0;
            r_data   <= 8'd0;
          end else begin
            r_count <= w_count_inc;
            if (w_count_inc == 5'd16) begin
              r_estado <= CHEIO;
              r_done   <= 1'b1;
            end else if (i_prog_mode) begin
              r_estado     <= ESPERA;
              r_byte_ready <= 1'b1;
            end else begin
              r_estado <= OCIOSO;
              r_busy   <= 1'b0;
              r_addr   <= 4'd0;
              r_data   <= 8'd0;
            end
          end
        end

        CHEIO: begin
          if (bus.byte_valid) begin
            r_erro <= 1'b1;
          end
          if (!i_prog_mode) begin
            r_estado <= OCIOSO;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_addr   <= 4'd0;
            r_data   <= 8'd0;
          end
        end

        default: begin
          r_estado     <= OCIOSO;
          r_byte_ready <= 1'b0;
          r_ce         <= 1'b0;
          r_le         <= 1'b1;
          r_run        <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready          = r_byte_ready;
  assign bus.ram_addr            = r_addr;
  assign bus.ram_data            = r_data;
  assign bus.ram_ce              = r_ce;
  assign bus.ram_leitura_escrita = r_le;
  assign bus.ram_run_prog        = r_run;
  assign bus.prog_busy           = r_busy;
  assign bus.prog_done           = r_done;
  assign bus.byte_count          = r_count;
  assign bus.erro_overflow       = r_erro;

endmodule

// File: tb/tb_carregador_ram.sv
// Bench for carregador_ram: a level-sensitive RAM model fed by the loader's write bus,
// with expected contents taken from the bytes the bench itself handed over.
module tb_carregador_ram;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic prog_mode = 1'b0;

  always #5 clk = ~clk;

  carregador_ram_if bus ();

  carregador_ram #(
    .SETUP_CYCLES (1),
    .STROBE_CYCLES(2),
    .HOLD_CYCLES  (1)
  ) dut (
    .i_clk      (clk),
    .i_clr_n    (clr_n),
    .i_prog_mode(prog_mode),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  byte unsigned ram_m[16];
  int           pulse_q[$];
  int           ready_cyc[$];
  int           ready_bad = 0;
  int           cyc = 0;
  int           strobe_len = 0;
  byte unsigned exp_q[$];

  // RAM model and bus observer, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (bus.ram_ce === 1'b1 && bus.ram_leitura_escrita === 1'b0 && bus.ram_run_prog === 1'b1) begin
      ram_m[bus.ram_addr] = bus.ram_data;
      strobe_len++;
    end else if (strobe_len != 0) begin
      pulse_q.push_back(strobe_len);
      strobe_len = 0;
    end
    if (bus.byte_ready === 1'b1) begin
      ready_cyc.push_back(cyc);
      if (bus.ram_ce !== 1'b0 || bus.prog_busy !== 1'b1 || bus.prog_done !== 1'b0) ready_bad++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bytes(input int n, input bit stall, input bit pattern, input int budget,
                            output int got);
    bit hs;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      bus.byte_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.byte_data  = pattern ? 8'(8'h10 + exp_q.size()) : 8'($urandom);
      hs = bus.byte_valid && (bus.byte_ready === 1'b1);
      tick();
      if (hs) begin
        exp_q.push_back(bus.byte_data);
        got++;
        $display("[%0t] byte %0d accepted: addr %0d data 0x%02h", $time, exp_q.size() - 1,
                 exp_q.size() - 1, bus.byte_data);
      end
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_write_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (bus.byte_ready === 1'b1 || bus.prog_done === 1'b1 || bus.prog_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_strobe(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (bus.ram_ce === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic new_session();
    prog_mode = 1'b0;
    tick();
    tick();
    prog_mode = 1'b1;
    tick();
    exp_q.delete();
  endtask

  task automatic test_reset();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    clr_n = 1'b0;
    prog_mode = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if ({bus.ram_ce, bus.ram_leitura_escrita, bus.ram_run_prog} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_strobe: got ce/le/run %b required 010",
               {bus.ram_ce, bus.ram_leitura_escrita, bus.ram_run_prog});
    end
    n_checks++;
    if ({bus.ram_addr, bus.ram_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %h data %h required 0/00", bus.ram_addr, bus.ram_data);
    end
    n_checks++;
    if ({bus.byte_ready, bus.prog_busy, bus.prog_done, bus.byte_count, bus.erro_overflow} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_status: got ready/busy/done/count/erro %b required all zero",
               {bus.byte_ready, bus.prog_busy, bus.prog_done, bus.byte_count, bus.erro_overflow});
    end
    prog_mode = 1'b0;
    clr_n = 1'b1;
    tick();
  endtask

  task automatic test_full_load();
    int got;
    int p0;
    int r0;
    int bad;
    new_session();
    p0 = pulse_q.size();
    r0 = ready_cyc.size();
    load_bytes(16, 1'b0, 1'b1, 200, got);
    n_checks++;
    if (got != 16) begin
      n_fail++;
      $display("FAIL full_accepted: got %0d bytes required 16", got);
    end
    for (int c = 0; c < 20 && bus.prog_done !== 1'b1; c++) tick();
    n_checks++;
    if ({bus.prog_done, bus.prog_busy, bus.byte_ready, bus.byte_count} !== {3'b110, 5'd16}) begin
      n_fail++;
      $display("FAIL full_status: got done %b busy %b ready %b count %0d required 1 1 0 16",
               bus.prog_done, bus.prog_busy, bus.byte_ready, bus.byte_count);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (ram_m[i] !== 8'(8'h10 + i)) begin
        n_fail++;
        $display("FAIL full_ram[%0d]: got %02h required %02h", i, ram_m[i], 8'(8'h10 + i));
      end
    end
    bad = 0;
    for (int i = p0; i < pulse_q.size(); i++) if (pulse_q[i] != 2) bad++;
    n_checks++;
    if (pulse_q.size() - p0 != 16 || bad != 0) begin
      n_fail++;
      $display("FAIL full_strobes: got %0d pulses (%0d not 2 cycles) required 16 of 2 cycles",
               pulse_q.size() - p0, bad);
    end
    bad = 0;
    for (int i = r0 + 1; i < ready_cyc.size(); i++) if (ready_cyc[i] - ready_cyc[i-1] != 5) bad++;
    n_checks++;
    if (ready_cyc.size() - r0 != 16 || bad != 0) begin
      n_fail++;
      $display("FAIL full_ready_period: got %0d ready cycles (%0d gaps not 5) required 16 every 5",
               ready_cyc.size() - r0, bad);
    end
  endtask

  task automatic test_overflow();
    int p0;
    int got;
    bit ok;
    p0 = pulse_q.size();
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    tick();
    tick();
    tick();
    bus.byte_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.erro_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag: got %b required 1", bus.erro_overflow);
    end
    n_checks++;
    if (pulse_q.size() != p0 || strobe_len != 0 || ram_m[15] !== 8'h1F) begin
      n_fail++;
      $display("FAIL ovf_no_write: got %0d new pulses ram15 %02h required 0 and 1f",
               pulse_q.size() - p0, ram_m[15]);
    end
    n_checks++;
    if ({bus.prog_done, bus.byte_count} !== {1'b1, 5'd16}) begin
      n_fail++;
      $display("FAIL ovf_done_hold: got done %b count %0d required 1 16", bus.prog_done, bus.byte_count);
    end
    prog_mode = 1'b0;
    tick();
    n_checks++;
    if ({bus.prog_done, bus.prog_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL ovf_exit: got done %b busy %b required 0 0", bus.prog_done, bus.prog_busy);
    end
    prog_mode = 1'b1;
    tick();
    n_checks++;
    if ({bus.erro_overflow, bus.byte_count, bus.byte_ready} !== {1'b0, 5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_new_session: got erro %b count %0d ready %b required 0 0 1",
               bus.erro_overflow, bus.byte_count, bus.byte_ready);
    end
    exp_q.delete();
    load_bytes(1, 1'b0, 1'b0, 20, got);
    wait_write_done(20, ok);
    n_checks++;
    if (!ok || got != 1 || ram_m[0] !== exp_q[0] || bus.byte_count !== 5'd1) begin
      n_fail++;
      $display("FAIL ovf_restart_addr0: got ok %b accepted %0d ram0 %02h count %0d required 1 1 %02h 1",
               ok, got, ram_m[0], bus.byte_count, exp_q[0]);
    end
  endtask

  task automatic test_stalls();
    int got;
    int p0;
    int bad;
    int rb0;
    new_session();
    p0 = pulse_q.size();
    rb0 = ready_bad;
    load_bytes(16, 1'b1, 1'b0, 2000, got);
    for (int c = 0; c < 20 && bus.prog_done !== 1'b1; c++) tick();
    n_checks++;
    if (got != 16 || bus.prog_done !== 1'b1 || bus.byte_count !== 5'd16) begin
      n_fail++;
      $display("FAIL stall_complete: got accepted %0d done %b count %0d required 16 1 16",
               got, bus.prog_done, bus.byte_count);
    end
    bad = 0;
    for (int i = 0; i < 16 && i < exp_q.size(); i++) if (ram_m[i] !== exp_q[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_ram: got %0d locations differing from bytes sent required 0", bad);
    end
    n_checks++;
    if (pulse_q.size() - p0 != 16) begin
      n_fail++;
      $display("FAIL stall_write_once: got %0d strobes required 16", pulse_q.size() - p0);
    end
    n_checks++;
    if (ready_bad != rb0) begin
      n_fail++;
      $display("FAIL stall_ready_outside: got %0d bad ready cycles required 0", ready_bad - rb0);
    end
  endtask

  task automatic test_abort_setup();
    int got;
    int p0;
    bit ok;
    new_session();
    load_bytes(4, 1'b0, 1'b0, 100, got);
    wait_write_done(20, ok);
    p0 = pulse_q.size();
    load_bytes(1, 1'b0, 1'b0, 20, got);
    n_checks++;
    if (got != 1 || bus.ram_addr !== 4'd4 || bus.ram_data !== exp_q[4] || bus.ram_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL setup_latch: got accepted %0d addr %0d data %02h ce %b required 1 4 %02h 0",
               got, bus.ram_addr, bus.ram_data, bus.ram_ce, exp_q[4]);
    end
    prog_mode = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if ({bus.prog_busy, bus.ram_ce, bus.byte_count} !== {2'b00, 5'd4} || pulse_q.size() != p0) begin
      n_fail++;
      $display("FAIL abort_setup: got busy %b ce %b count %0d new pulses %0d required 0 0 4 0",
               bus.prog_busy, bus.ram_ce, bus.byte_count, pulse_q.size() - p0);
    end
  endtask

  task automatic test_abort_strobe();
    int got;
    int p0;
    bit ok;
    new_session();
    load_bytes(4, 1'b0, 1'b0, 100, got);
    wait_write_done(20, ok);
    p0 = pulse_q.size();
    load_bytes(1, 1'b0, 1'b0, 20, got);
    wait_strobe(10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL strobe_seen: got no strobe within 10 cycles required one");
    end
    prog_mode = 1'b0;
    tick();
    n_checks++;
    if ({bus.ram_ce, bus.ram_run_prog, bus.prog_busy} !== 3'b001 || bus.ram_addr !== 4'd4) begin
      n_fail++;
      $display("FAIL strobe_cut_hold: got ce %b run %b busy %b addr %0d required 0 0 1 4",
               bus.ram_ce, bus.ram_run_prog, bus.prog_busy, bus.ram_addr);
    end
    tick();
    tick();
    n_checks++;
    if ({bus.prog_busy, bus.byte_count} !== {1'b0, 5'd4}) begin
      n_fail++;
      $display("FAIL strobe_abort_count: got busy %b count %0d required 0 4", bus.prog_busy, bus.byte_count);
    end
    n_checks++;
    if (pulse_q.size() != p0 + 1 || pulse_q[pulse_q.size()-1] != 1) begin
      n_fail++;
      $display("FAIL strobe_cut_len: got %0d new pulses last len %0d required 1 of 1 cycle",
               pulse_q.size() - p0, pulse_q[pulse_q.size()-1]);
    end
  endtask

  task automatic test_reset_mid_strobe();
    int got;
    bit ok;
    new_session();
    load_bytes(2, 1'b0, 1'b0, 100, got);
    wait_write_done(20, ok);
    load_bytes(1, 1'b0, 1'b0, 20, got);
    wait_strobe(10, ok);
    clr_n = 1'b0;
    tick();
    n_checks++;
    if ({bus.ram_ce, bus.ram_run_prog, bus.ram_leitura_escrita} !== 3'b001 || !ok) begin
      n_fail++;
      $display("FAIL rst_strobe_bus: got ce %b run %b le %b (strobe seen %b) required 0 0 1",
               bus.ram_ce, bus.ram_run_prog, bus.ram_leitura_escrita, ok);
    end
    n_checks++;
    if ({bus.byte_count, bus.prog_busy, bus.byte_ready, bus.prog_done} !== 8'b0) begin
      n_fail++;
      $display("FAIL rst_strobe_status: got count %0d busy %b ready %b done %b required all zero",
               bus.byte_count, bus.prog_busy, bus.byte_ready, bus.prog_done);
    end
    prog_mode = 1'b0;
    clr_n = 1'b1;
    tick();
    n_checks++;
    if (bus.prog_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_strobe_idle: got busy %b required 0", bus.prog_busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_overflow();
    test_stalls();
    test_abort_setup();
    test_abort_strobe();
    test_reset_mid_strobe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
